// File: rtl/vend_pkg.sv
// Shared vending-controller definitions: state codes, coin encodings/values, price table.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    localparam int unsigned DEFAULT_MAX_CREDIT = 200;

    localparam logic [7:0] PRICE [4] = '{8'd50, 8'd65, 8'd75, 8'd100};

    function automatic logic [7:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_5:  coin_value = 8'd5;
            COIN_10: coin_value = 8'd10;
            COIN_25: coin_value = 8'd25;
            default: coin_value = 8'd0;
        endcase
    endfunction

    // Greedy change: largest coin not exceeding the remaining credit.
    function automatic logic [1:0] largest_coin(input logic [7:0] amount);
        if (amount >= 8'd25)      largest_coin = COIN_25;
        else if (amount >= 8'd10) largest_coin = COIN_10;
        else if (amount >= 8'd5)  largest_coin = COIN_5;
        else                      largest_coin = COIN_NONE;
    endfunction

endpackage

// File: rtl/vend_state_enc.sv
// Binary-to-one-hot state decoder; purely combinational from the registered state.
module vend_state_enc (
    input  logic [1:0] state_bin,
    output logic [3:0] state_onehot
);

    assign state_onehot = 4'b0001 << state_bin;

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: coin credit accounting, item dispense handshake, greedy change return.
// All outputs registered; one-hot state is decoded from the registered binary state.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = DEFAULT_MAX_CREDIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    input  logic       disp_ready,
    input  logic       chg_ready,
    output logic [7:0] credit,
    output logic       disp_valid,
    output logic [1:0] disp_item,
    output logic       chg_valid,
    output logic [1:0] chg_coin,
    output logic       coin_reject,
    output logic       sel_deny,
    output logic [1:0] state_binary,
    output logic [3:0] state_onehot
);

    localparam logic [8:0] MAX_C = 9'(MAX_CREDIT);

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic       disp_valid_q, disp_valid_d;
    logic [1:0] disp_item_q, disp_item_d;
    logic       chg_valid_q, chg_valid_d;
    logic [1:0] chg_coin_q, chg_coin_d;
    logic       coin_reject_q, coin_reject_d;
    logic       sel_deny_q, sel_deny_d;

    logic [8:0] coin_sum;
    logic       coin_ok;
    logic       claimed;
    logic [7:0] price;
    logic [7:0] chg_rem;

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
    assign coin_ok  = (coin_type != COIN_NONE) && (coin_sum <= MAX_C);
    assign price    = PRICE[sel_item];
    assign chg_rem  = credit_q - coin_value(chg_coin_q);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_valid_d  = disp_valid_q;
        disp_item_d   = disp_item_q;
        chg_valid_d   = chg_valid_q;
        chg_coin_d    = chg_coin_q;
        coin_reject_d = 1'b0;
        sel_deny_d    = 1'b0;
        claimed       = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                // An honoured cancel/selection claims the cycle, so a coin alongside it bounces.
                if (state_q == ST_COLLECT && cancel) begin
                    claimed = 1'b1;
                    if (credit_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_CHANGE;
                        chg_valid_d = 1'b1;
                        chg_coin_d  = largest_coin(credit_q);
                    end
                end else if (sel_valid) begin
                    if (state_q == ST_COLLECT && credit_q >= price) begin
                        claimed      = 1'b1;
                        credit_d     = credit_q - price;
                        disp_item_d  = sel_item;
                        disp_valid_d = 1'b1;
                        state_d      = ST_DISPENSE;
                    end else begin
                        sel_deny_d = 1'b1;
                    end
                end
                if (coin_valid) begin
                    if (claimed || !coin_ok) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[7:0];
                        state_d  = ST_COLLECT;
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (disp_ready) begin
                    disp_valid_d = 1'b0;
                    if (credit_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_CHANGE;
                        chg_valid_d = 1'b1;
                        chg_coin_d  = largest_coin(credit_q);
                    end
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (chg_ready) begin
                    credit_d = chg_rem;
                    if (chg_rem == 8'd0) begin
                        state_d     = ST_IDLE;
                        chg_valid_d = 1'b0;
                        chg_coin_d  = COIN_NONE;
                    end else begin
                        chg_coin_d = largest_coin(chg_rem);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= 8'd0;
            disp_valid_q  <= 1'b0;
            disp_item_q   <= 2'd0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= COIN_NONE;
            coin_reject_q <= 1'b0;
            sel_deny_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_valid_q  <= disp_valid_d;
            disp_item_q   <= disp_item_d;
            chg_valid_q   <= chg_valid_d;
            chg_coin_q    <= chg_coin_d;
            coin_reject_q <= coin_reject_d;
            sel_deny_q    <= sel_deny_d;
        end
    end

    assign credit       = credit_q;
    assign disp_valid   = disp_valid_q;
    assign disp_item    = disp_item_q;
    assign chg_valid    = chg_valid_q;
    assign chg_coin     = chg_coin_q;
    assign coin_reject  = coin_reject_q;
    assign sel_deny     = sel_deny_q;
    assign state_binary = state_q;

    vend_state_enc u_state_enc (
        .state_bin    (state_q),
        .state_onehot (state_onehot)
    );

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed table-driven bench for vend_ctrl: one record per clock, plus async-reset sequences.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid, sel_valid, cancel, disp_ready, chg_ready;
    logic [1:0] coin_type, sel_item;
    logic [7:0] credit;
    logic       disp_valid, chg_valid, coin_reject, sel_deny;
    logic [1:0] disp_item, chg_coin, state_binary;
    logic [3:0] state_onehot;

    typedef struct {
        logic       cv;
        logic [1:0] ct;
        logic       sv;
        logic [1:0] si;
        logic       cn;
        logic       dr;
        logic       cr;
        logic [7:0] e_cred;
        logic [1:0] e_st;
        logic       e_dv;
        logic [1:0] e_di;
        logic       e_chv;
        logic [1:0] e_chc;
        logic       e_rj;
        logic       e_dn;
    } vec_t;

    vec_t tbl[$];
    int   applied = 0;
    int   miscompares = 0;

    vend_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .disp_ready   (disp_ready),
        .chg_ready    (chg_ready),
        .credit       (credit),
        .disp_valid   (disp_valid),
        .disp_item    (disp_item),
        .chg_valid    (chg_valid),
        .chg_coin     (chg_coin),
        .coin_reject  (coin_reject),
        .sel_deny     (sel_deny),
        .state_binary (state_binary),
        .state_onehot (state_onehot)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic cv, input logic [1:0] ct, input logic sv,
                                input logic [1:0] si, input logic cn, input logic dr, input logic cr,
                                input int cred, input logic [1:0] st, input logic dv,
                                input logic [1:0] di, input logic chv, input logic [1:0] chc,
                                input logic rj, input logic dn);
        vec_t v;
        v.cv = cv; v.ct = ct; v.sv = sv; v.si = si; v.cn = cn; v.dr = dr; v.cr = cr;
        v.e_cred = 8'(cred); v.e_st = st; v.e_dv = dv; v.e_di = di;
        v.e_chv = chv; v.e_chc = chc; v.e_rj = rj; v.e_dn = dn;
        return v;
    endfunction

    task automatic add(input logic cv, input logic [1:0] ct, input logic sv, input logic [1:0] si,
                       input logic cn, input logic dr, input logic cr, input int cred,
                       input logic [1:0] st, input logic dv, input logic [1:0] di,
                       input logic chv, input logic [1:0] chc, input logic rj, input logic dn);
        tbl.push_back(mk(cv, ct, sv, si, cn, dr, cr, cred, st, dv, di, chv, chc, rj, dn));
    endtask

    task automatic check(input vec_t v, input string name);
        logic [3:0]  exp_oh;
        logic [20:0] act, exp;
        exp_oh = 4'b0001 << v.e_st;
        act = {credit, state_binary, state_onehot, disp_valid, disp_item, chg_valid, chg_coin,
               coin_reject, sel_deny};
        exp = {v.e_cred, v.e_st, exp_oh, v.e_dv, v.e_di, v.e_chv, v.e_chc, v.e_rj, v.e_dn};
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got cred=%0d st=%0d oh=%b dv=%b di=%0d chv=%b chc=%0d rj=%b dn=%b, want cred=%0d st=%0d oh=%b dv=%b di=%0d chv=%b chc=%0d rj=%b dn=%b",
                     name, credit, state_binary, state_onehot, disp_valid, disp_item, chg_valid,
                     chg_coin, coin_reject, sel_deny, v.e_cred, v.e_st, exp_oh, v.e_dv, v.e_di,
                     v.e_chv, v.e_chc, v.e_rj, v.e_dn);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        coin_valid = v.cv; coin_type = v.ct; sel_valid = v.sv; sel_item = v.si;
        cancel = v.cn; disp_ready = v.dr; chg_ready = v.cr;
        @(posedge clk);
        #1;
        check(v, name);
    endtask

    initial begin
        vec_t zero_v;
        rst = 1'b0;
        coin_valid = 1'b0; coin_type = 2'b00; sel_valid = 1'b0; sel_item = 2'd0;
        cancel = 1'b0; disp_ready = 1'b0; chg_ready = 1'b0;
        zero_v = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0);

        // Exact purchase: 3 x 25, item2 (75)
        add(1,3,0,0,0,0,0,  25,1,0,0,0,0,0,0);
        add(1,3,0,0,0,0,0,  50,1,0,0,0,0,0,0);
        add(1,3,0,0,0,0,0,  75,1,0,0,0,0,0,0);
        add(0,0,1,2,0,0,0,   0,2,1,2,0,0,0,0);
        add(0,0,0,0,0,0,0,   0,2,1,2,0,0,0,0);
        add(0,0,0,0,0,1,0,   0,0,0,2,0,0,0,0);
        // Change return: 100 in, item1 (65), change 25 then 10
        add(1,3,0,0,0,0,0,  25,1,0,2,0,0,0,0);
        add(1,3,0,0,0,0,0,  50,1,0,2,0,0,0,0);
        add(1,3,0,0,0,0,0,  75,1,0,2,0,0,0,0);
        add(1,3,0,0,0,0,0, 100,1,0,2,0,0,0,0);
        add(0,0,1,1,0,0,0,  35,2,1,1,0,0,0,0);
        add(0,0,0,0,0,1,0,  35,3,0,1,1,3,0,0);
        add(0,0,0,0,0,0,0,  35,3,0,1,1,3,0,0);
        add(0,0,0,0,0,0,1,  10,3,0,1,1,2,0,0);
        add(0,0,0,0,0,0,1,   0,0,0,1,0,0,0,0);
        // Denial in IDLE and COLLECT, then refund; inputs ignored in CHANGE
        add(0,0,1,0,0,0,0,   0,0,0,1,0,0,0,1);
        add(1,3,0,0,0,0,0,  25,1,0,1,0,0,0,0);
        add(0,0,1,3,0,0,0,  25,1,0,1,0,0,0,1);
        add(0,0,0,0,1,0,0,  25,3,0,1,1,3,0,0);
        add(1,3,1,0,1,0,0,  25,3,0,1,1,3,1,0);
        add(0,0,0,0,0,0,1,   0,0,0,1,0,0,0,0);
        // Invalid coin encoding
        add(1,0,0,0,0,0,0,   0,0,0,1,0,0,1,0);
        // Overflow: build 190, reject 25, accept 10 up to 200 exactly, reject 5
        for (int k = 1; k <= 7; k++) add(1,3,0,0,0,0,0, 25*k,1,0,1,0,0,0,0);
        add(1,2,0,0,0,0,0, 185,1,0,1,0,0,0,0);
        add(1,1,0,0,0,0,0, 190,1,0,1,0,0,0,0);
        add(1,3,0,0,0,0,0, 190,1,0,1,0,0,1,0);
        add(1,2,0,0,0,0,0, 200,1,0,1,0,0,0,0);
        add(1,1,0,0,0,0,0, 200,1,0,1,0,0,1,0);
        add(0,0,1,3,0,0,0, 100,2,1,3,0,0,0,0);
        add(1,1,0,0,0,0,0, 100,2,1,3,0,0,1,0);
        add(0,0,0,0,0,1,0, 100,3,0,3,1,3,0,0);
        add(0,0,0,0,0,0,1,  75,3,0,3,1,3,0,0);
        add(0,0,0,0,0,0,1,  50,3,0,3,1,3,0,0);
        add(0,0,0,0,0,0,1,  25,3,0,3,1,3,0,0);
        add(0,0,0,0,0,0,1,   0,0,0,3,0,0,0,0);
        // Coin together with honoured selection at 75, item2
        add(1,3,0,0,0,0,0,  25,1,0,3,0,0,0,0);
        add(1,3,0,0,0,0,0,  50,1,0,3,0,0,0,0);
        add(1,3,0,0,0,0,0,  75,1,0,3,0,0,0,0);
        add(1,3,1,2,0,0,0,   0,2,1,2,0,0,1,0);
        add(0,0,0,0,0,1,0,   0,0,0,2,0,0,0,0);
        // Coin with denied selection is accepted; cancel beats selection and coin
        add(1,2,0,0,0,0,0,  10,1,0,2,0,0,0,0);
        add(1,3,1,0,0,0,0,  35,1,0,2,0,0,0,1);
        add(1,1,1,0,1,0,0,  35,3,0,2,1,3,1,0);
        add(0,0,0,0,0,0,1,  10,3,0,2,1,2,0,0);
        add(0,0,0,0,0,0,1,   0,0,0,2,0,0,0,0);

        #12;
        check(zero_v, "reset_state");

        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted mid-CHANGE, checked before any clock edge
        apply(mk(1,2,0,0,0,0,0, 10,1,0,2,0,0,0,0), "pre_rst_coin");
        apply(mk(0,0,0,0,1,0,0, 10,3,0,2,1,2,0,0), "pre_rst_cancel");
        apply(mk(0,0,0,0,0,0,0, 10,3,0,2,1,2,0,0), "pre_rst_hold");
        chg_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        check(zero_v, "rst_mid_change");
        @(posedge clk);
        #1;
        check(zero_v, "rst_held_edge");
        @(negedge clk);
        rst = 1'b1;
        apply(mk(1,1,0,0,0,0,0, 5,1,0,0,0,0,0,0), "first_edge_after_rst");

        // Reset asserted mid-DISPENSE
        apply(mk(1,3,0,0,0,0,0, 30,1,0,0,0,0,0,0), "pre_rst2_coin1");
        apply(mk(1,3,0,0,0,0,0, 55,1,0,0,0,0,0,0), "pre_rst2_coin2");
        apply(mk(0,0,1,0,0,0,0,  5,2,1,0,0,0,0,0), "pre_rst2_sel");
        #1 rst = 1'b0;
        #1;
        check(zero_v, "rst_mid_dispense");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter MAX_CREDIT, default 200, meaning the highest credit value in cents.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port coin_valid, input, 1 bit: coin present this cycle.
REQ-005 SHALL have port coin_type, input, 2 bits: 01=5, 10=10, 11=25 cents; 00 is invalid.
REQ-006 SHALL have port sel_valid, input, 1 bit: product selection strobe.
REQ-007 SHALL have port sel_item, input, 2 bits: item index 0-3.
REQ-008 SHALL have port cancel, input, 1 bit: refund request.
REQ-009 SHALL have port disp_ready, input, 1 bit: dispenser accepts the item.
REQ-010 SHALL have port chg_ready, input, 1 bit: coin hopper accepts one change coin.
REQ-011 SHALL have port credit, output, 8 bits: current credit in cents.
REQ-012 SHALL have ports disp_valid (output, 1 bit) and disp_item (output, 2 bits): dispense request and item index.
REQ-013 SHALL have ports chg_valid (output, 1 bit) and chg_coin (output, 2 bits): change request, coin encoded as coin_type.
REQ-014 SHALL have port coin_reject, output, 1 bit: one-cycle pulse when a coin is not accepted.
REQ-015 SHALL have port sel_deny, output, 1 bit: one-cycle pulse when a selection is not honoured.
REQ-016 SHALL have ports state_binary (output, 2 bits) and state_onehot (output, 4 bits): FSM state in binary and one-hot encodings.

Function
REQ-017 SHALL implement states IDLE(0/0001), COLLECT(1/0010), DISPENSE(2/0100), CHANGE(3/1000), listed as binary/one-hot.
REQ-018 SHALL register all outputs; an input sampled at edge N is reflected in the outputs immediately after edge N.
REQ-019 SHALL keep state_onehot equal to 1 << state_binary in every cycle.
REQ-020 SHALL, in IDLE or COLLECT, accept a valid coin by adding its value to credit and moving IDLE to COLLECT.
REQ-021 SHALL reject (coin_reject pulse, credit unchanged) a coin in any of these cases:
- coin_type is 00;
- credit plus the coin value exceeds MAX_CREDIT;
- the state is DISPENSE or CHANGE;
- the coin arrives in the same cycle as an honoured sel_valid or cancel.
REQ-022 SHALL apply input priority in COLLECT as cancel > sel_valid > coin_valid.
REQ-023 SHALL, in COLLECT, on cancel, go to CHANGE with credit retained.
REQ-024 SHALL, in COLLECT, on sel_valid with credit >= PRICE[sel_item]: subtract the price from credit, latch disp_item, and go to DISPENSE.
REQ-025 SHALL, on sel_valid with insufficient credit or while in IDLE, pulse sel_deny and leave state unchanged.
REQ-026 SHALL, in DISPENSE, hold disp_valid=1 and disp_item stable until disp_ready is sampled high.
REQ-027 SHALL, on that disp_ready handshake, clear disp_valid and go to IDLE if credit is 0, otherwise to CHANGE.
REQ-028 SHALL, in CHANGE, drive chg_valid=1 with chg_coin set to the largest coin value (25, 10, 5) that is <= credit.
REQ-029 SHALL, on each chg_ready handshake in CHANGE, subtract the coin value from credit.
REQ-030 SHALL, when credit reaches 0 in CHANGE, deassert chg_valid and go to IDLE in the same update.
REQ-031 SHALL keep chg_coin stable while chg_valid=1 and chg_ready=0.
REQ-032 SHALL ignore cancel and sel_valid in DISPENSE and CHANGE, and SHALL NOT pulse sel_deny in those states.
REQ-033 SHALL keep credit a multiple of 5 in the range 0..MAX_CREDIT; CHANGE therefore always terminates.

Reset
REQ-034 SHALL, on rst low at any time (including mid-DISPENSE or mid-CHANGE), immediately force the following, with no handshake completion:
- state IDLE, state_binary=00, state_onehot=0001;
- credit=0;
- disp_valid, disp_item, chg_valid, chg_coin, coin_reject and sel_deny all 0.
REQ-035 SHALL leave reset synchronously to clk; the first active edge after rst rises evaluates inputs normally.

Structure
REQ-036 SHALL place the state codes, coin_type encodings, coin values, the PRICE table (item0=50, item1=65, item2=75, item3=100) and the default MAX_CREDIT in the shared package vend_pkg.
REQ-037 SHALL instantiate a single sub-module, vend_state_enc, that converts the binary state into the one-hot output.

Verification
REQ-038 SHALL cover reset: rst low -> credit=0, state_binary=0, state_onehot=0001, disp_valid=0, chg_valid=0.
REQ-039 SHALL cover an exact purchase: coins 25, 25, 25, then sel_item=2 -> credit 0 and DISPENSE (0100); after disp_ready -> IDLE.
REQ-040 SHALL cover change return: 100 inserted, sel_item=1 -> credit 35 and DISPENSE; after disp_ready -> CHANGE with chg_coin=25, then 10 over two chg_ready handshakes -> IDLE.
REQ-041 SHALL cover denial and refund: 25 inserted, sel_item=3 -> sel_deny pulse, credit 25; then cancel -> CHANGE, one 25 returned -> IDLE.
REQ-042 SHALL cover overflow and simultaneous inputs:
- credit 190 plus a 25 coin -> coin_reject, credit stays 190;
- coin together with sel_valid at credit 75, sel_item=2 -> coin_reject, DISPENSE.
REQ-043 SHALL cover reset mid-operation: rst low while chg_valid=1 -> all outputs return to reset values within the same cycle.
